nonce_dispatcher: RTL and testbench

Work scheduler that shares a 32-bit nonce search space among `NUM_PE` SHA-256 mining processing elements. It hands out fixed-size nonce chunks through a per-PE request/acknowledge handshake with round-robin arbitration. It also tracks outstanding chunks, latches the first winning nonce, and broadcasts a stop. It sits above the processing-element array and below the board-level display/LED logic.

---
 rtl/nonce_dispatcher.sv | 197 +++++++++++++++++++
 tb/tb_nonce_dispatcher.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/nonce_dispatcher.sv
// ============================================================================
// Module      : nonce_dispatcher
// Description : Round-robin nonce chunk scheduler for an array of SHA-256 PEs,
//               with first-hit latch, exhaustion detection and stop broadcast.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonce_dispatcher #(
    parameter int NUM_PE  = 4,
    parameter int RANGE_W = 16
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           base_nonce,
    input  logic [NUM_PE-1:0]     pe_req,
    input  logic [NUM_PE-1:0]     pe_done,
    input  logic [NUM_PE-1:0]     pe_found,
    input  logic [32*NUM_PE-1:0]  pe_found_nonce,
    output logic [NUM_PE-1:0]     pe_ack,
    output logic [31:0]           pe_nonce_base,
    output logic                  pe_stop,
    output logic                  busy,
    output logic                  found,
    output logic [31:0]           found_nonce,
    output logic [NUM_PE-1:0]     found_pe,
    output logic                  exhausted
);

    localparam int CHUNK_W = 32 - RANGE_W;
    localparam int PTR_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    state_t               state_q;
    logic [CHUNK_W-1:0]   next_chunk_q;
    logic [CHUNK_W:0]     chunks_left_q;
    logic [NUM_PE-1:0]    outstanding_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [NUM_PE-1:0]    ack_q;
    logic [31:0]          nonce_base_q;
    logic                 stop_q;
    logic                 found_q;
    logic [31:0]          found_nonce_q;
    logic [NUM_PE-1:0]    found_pe_q;
    logic                 exhausted_q;

    logic [NUM_PE-1:0]    eligible_d;
    logic [NUM_PE-1:0]    hit_d;
    logic                 hit_any_d;
    logic [NUM_PE-1:0]    hit_onehot_d;
    logic [31:0]          hit_nonce_d;
    logic                 grant_any_d;
    logic [PTR_W-1:0]     grant_idx_d;
    logic [NUM_PE-1:0]    grant_onehot_d;
    logic [PTR_W-1:0]     rr_ptr_d;
    logic [NUM_PE-1:0]    outstanding_d;
    logic [CHUNK_W:0]     chunks_init_d;
    logic                 start_job_d;

    always_comb begin
        eligible_d     = pe_req & ~outstanding_q & {NUM_PE{chunks_left_q != '0}};
        hit_d          = pe_found & outstanding_q;
        hit_any_d      = |hit_d;
        hit_onehot_d   = '0;
        hit_nonce_d    = '0;
        // Descending scan so the lowest simultaneous hit is the one kept.
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (hit_d[i]) begin
                hit_onehot_d = '0;
                hit_onehot_d[i] = 1'b1;
                hit_nonce_d  = pe_found_nonce[32*i +: 32];
            end
        end

        grant_any_d    = 1'b0;
        grant_idx_d    = '0;
        grant_onehot_d = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_PE) idx = idx - NUM_PE;
            if (!grant_any_d && eligible_d[idx]) begin
                grant_any_d         = 1'b1;
                grant_idx_d         = PTR_W'(idx);
                grant_onehot_d[idx] = 1'b1;
            end
        end

        if (grant_idx_d == PTR_W'(NUM_PE - 1)) rr_ptr_d = '0;
        else                                    rr_ptr_d = grant_idx_d + PTR_W'(1);

        outstanding_d = (outstanding_q & ~pe_done) | grant_onehot_d;
        chunks_init_d = {1'b1, {CHUNK_W{1'b0}}} - {1'b0, base_nonce[31:RANGE_W]};
        start_job_d   = start && ((state_q == S_IDLE) || (state_q == S_DONE && !abort));
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            next_chunk_q  <= '0;
            chunks_left_q <= '0;
            outstanding_q <= '0;
            rr_ptr_q      <= '0;
            ack_q         <= '0;
            nonce_base_q  <= '0;
            stop_q        <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            found_pe_q    <= '0;
            exhausted_q   <= 1'b0;
        end else begin
            ack_q        <= '0;
            nonce_base_q <= '0;
            stop_q       <= 1'b0;
            if (start_job_d) begin
                state_q       <= S_DISPATCH;
                next_chunk_q  <= base_nonce[31:RANGE_W];
                chunks_left_q <= chunks_init_d;
                outstanding_q <= '0;
                rr_ptr_q      <= '0;
                found_q       <= 1'b0;
                found_nonce_q <= '0;
                found_pe_q    <= '0;
                exhausted_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_DISPATCH: begin
                        if (abort) begin
                            state_q       <= S_IDLE;
                            stop_q        <= 1'b1;
                            outstanding_q <= '0;
                            found_q       <= 1'b0;
                            found_nonce_q <= '0;
                            found_pe_q    <= '0;
                            exhausted_q   <= 1'b0;
                        end else if (hit_any_d) begin
                            state_q       <= S_DONE;
                            stop_q        <= 1'b1;
                            found_q       <= 1'b1;
                            found_nonce_q <= hit_nonce_d;
                            found_pe_q    <= hit_onehot_d;
                        end else begin
                            outstanding_q <= outstanding_d;
                            if (grant_any_d) begin
                                ack_q         <= grant_onehot_d;
                                nonce_base_q  <= {next_chunk_q, {RANGE_W{1'b0}}};
                                chunks_left_q <= chunks_left_q - {{CHUNK_W{1'b0}}, 1'b1};
                                rr_ptr_q      <= rr_ptr_d;
                                // Hold at the top chunk instead of wrapping to zero.
                                if (chunks_left_q != {{CHUNK_W{1'b0}}, 1'b1})
                                    next_chunk_q <= next_chunk_q + {{(CHUNK_W-1){1'b0}}, 1'b1};
                            end
                            if (chunks_left_q == '0 && (outstanding_q & ~pe_done) == '0) begin
                                state_q     <= S_DONE;
                                stop_q      <= 1'b1;
                                exhausted_q <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (abort) begin
                            state_q       <= S_IDLE;
                            outstanding_q <= '0;
                            found_q       <= 1'b0;
                            found_nonce_q <= '0;
                            found_pe_q    <= '0;
                            exhausted_q   <= 1'b0;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign pe_ack        = ack_q;
    assign pe_nonce_base = nonce_base_q;
    assign pe_stop       = stop_q;
    assign busy          = (state_q == S_DISPATCH);
    assign found         = found_q;
    assign found_nonce   = found_nonce_q;
    assign found_pe      = found_pe_q;
    assign exhausted     = exhausted_q;

endmodule

`default_nettype wire

// File: tb/tb_nonce_dispatcher.sv
// ============================================================================
// Module      : tb_nonce_dispatcher
// Description : Directed self-checking bench for nonce_dispatcher (4 PEs, 64K chunks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nonce_dispatcher;

    logic         clk = 1'b0;
    logic         reset, start, abort;
    logic [31:0]  base_nonce;
    logic [3:0]   pe_req, pe_done, pe_found;
    logic [127:0] pe_found_nonce;
    logic [3:0]   pe_ack;
    logic [31:0]  pe_nonce_base;
    logic         pe_stop, busy, found, exhausted;
    logic [31:0]  found_nonce;
    logic [3:0]   found_pe;

    int total = 0;
    int bad   = 0;

    nonce_dispatcher #(.NUM_PE(4), .RANGE_W(16)) dut (
        .sys_clk        (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .base_nonce     (base_nonce),
        .pe_req         (pe_req),
        .pe_done        (pe_done),
        .pe_found       (pe_found),
        .pe_found_nonce (pe_found_nonce),
        .pe_ack         (pe_ack),
        .pe_nonce_base  (pe_nonce_base),
        .pe_stop        (pe_stop),
        .busy           (busy),
        .found          (found),
        .found_nonce    (found_nonce),
        .found_pe       (found_pe),
        .exhausted      (exhausted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_nonce = '0;
        pe_req = '0; pe_done = '0; pe_found = '0; pe_found_nonce = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_ack",   32'(pe_ack), 0);
        chk("rst_base",  pe_nonce_base, 0);
        chk("rst_stop",  32'(pe_stop), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_found", 32'(found), 0);
        chk("rst_exh",   32'(exhausted), 0);
        chk("rst_fpe",   32'(found_pe), 0);
        chk("rst_fnon",  found_nonce, 0);

        // Job 1: four back-to-back grants in order
        base_nonce = 32'h0; start = 1'b1; pe_req = 4'hF;
        step(); start = 1'b0;
        chk("j1_busy", 32'(busy), 1);
        chk("j1_ack0", 32'(pe_ack), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("j1_ack%0d", i), 32'(pe_ack), 32'(1 << i));
            chk($sformatf("j1_base%0d", i), pe_nonce_base, 32'(i) << 16);
        end
        step();
        chk("j1_full_noack", 32'(pe_ack), 0);
        pe_req = 4'h0; pe_done = 4'b0101;
        step(); pe_done = 4'h0;
        chk("j1_done_noack", 32'(pe_ack), 0);
        pe_req = 4'b0101;
        step();
        chk("fair_ack_pe0",  32'(pe_ack), 32'h1);
        chk("fair_base_pe0", pe_nonce_base, 32'h0004_0000);
        pe_req = 4'b0100;
        step();
        chk("fair_ack_pe2",  32'(pe_ack), 32'h4);
        chk("fair_base_pe2", pe_nonce_base, 32'h0005_0000);
        pe_req = 4'h0; pe_done = 4'b0001;
        step(); pe_done = 4'h0; pe_req = 4'b0001;
        step();
        chk("wrap_ack_pe0",  32'(pe_ack), 32'h1);
        chk("wrap_base_pe0", pe_nonce_base, 32'h0006_0000);
        pe_req = 4'h0; pe_done = 4'b0010;
        step(); pe_done = 4'h0;

        // Single hit from PE2 while PE1 requests
        pe_req = 4'b0010; pe_found = 4'b0100;
        pe_found_nonce[64 +: 32] = 32'h0002_1234;
        step(); pe_found = 4'h0;
        chk("hit_found", 32'(found), 1);
        chk("hit_nonce", found_nonce, 32'h0002_1234);
        chk("hit_pe",    32'(found_pe), 32'h4);
        chk("hit_stop",  32'(pe_stop), 1);
        chk("hit_ack",   32'(pe_ack), 0);
        chk("hit_busy",  32'(busy), 0);
        step();
        chk("hit_hold_ack",   32'(pe_ack), 0);
        chk("hit_hold_found", 32'(found), 1);
        chk("hit_hold_stop",  32'(pe_stop), 1);

        // Job 2 from DONE: simultaneous hits, lowest index wins
        base_nonce = 32'h0; start = 1'b1; pe_req = 4'hF;
        step(); start = 1'b0;
        chk("j2_busy",  32'(busy), 1);
        chk("j2_found", 32'(found), 0);
        chk("j2_stop",  32'(pe_stop), 0);
        chk("j2_fnon",  found_nonce, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("j2_ack%0d", i), 32'(pe_ack), 32'(1 << i));
        end
        pe_req = 4'h0; pe_found = 4'b1010;
        pe_found_nonce[32 +: 32] = 32'h0001_0007;
        pe_found_nonce[96 +: 32] = 32'h0003_0001;
        step(); pe_found = 4'h0;
        chk("multi_pe",    32'(found_pe), 32'h2);
        chk("multi_nonce", found_nonce, 32'h0001_0007);
        abort = 1'b1;
        step(); abort = 1'b0;
        chk("done_abort_busy",  32'(busy), 0);
        chk("done_abort_found", 32'(found), 0);
        chk("done_abort_fpe",   32'(found_pe), 0);

        // Job 3: found from an idle PE ignored, then abort with three outstanding
        start = 1'b1; pe_req = 4'b0111;
        step(); start = 1'b0;
        step(); step(); step();
        chk("j3_ack2", 32'(pe_ack), 32'h4);
        pe_req = 4'h0; pe_found = 4'b1000;
        pe_found_nonce[96 +: 32] = 32'hDEAD_BEEF;
        step(); pe_found = 4'h0;
        chk("stray_found", 32'(found), 0);
        chk("stray_busy",  32'(busy), 1);
        abort = 1'b1;
        step(); abort = 1'b0;
        chk("abort_stop", 32'(pe_stop), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_fnon", found_nonce, 0);
        step();
        chk("abort_stop_gone", 32'(pe_stop), 0);
        start = 1'b1; pe_req = 4'hF;
        step(); start = 1'b0;
        step();
        chk("post_abort_pe0", 32'(pe_ack), 32'h1);

        // Reset mid-job, with a competing start
        reset = 1'b1; start = 1'b1;
        step(); reset = 1'b0; start = 1'b0; pe_req = 4'h0;
        chk("midrst_ack",  32'(pe_ack), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_stop", 32'(pe_stop), 0);

        // Exhaustion near the top of the nonce space
        base_nonce = 32'hFFFE_5555; start = 1'b1; pe_req = 4'b0011;
        step(); start = 1'b0;
        chk("ex_busy", 32'(busy), 1);
        step();
        chk("ex_ack0",  32'(pe_ack), 32'h1);
        chk("ex_base0", pe_nonce_base, 32'hFFFE_0000);
        step();
        chk("ex_ack1",  32'(pe_ack), 32'h2);
        chk("ex_base1", pe_nonce_base, 32'hFFFF_0000);
        pe_req = 4'hF;
        step();
        chk("ex_noack", 32'(pe_ack), 0);
        chk("ex_notyet", 32'(exhausted), 0);
        pe_req = 4'h0; pe_done = 4'b0011;
        step(); pe_done = 4'h0;
        chk("ex_exh",   32'(exhausted), 1);
        chk("ex_found", 32'(found), 0);
        chk("ex_stop",  32'(pe_stop), 1);
        chk("ex_busy0", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
